// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared FSM/requester encodings and download limit default
package rom_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_e;
    typedef enum logic {SEL_VID, SEL_CPU} sel_e;
    localparam logic [24:0] DL_LIMIT_DEFAULT = 25'h20000;
endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: download, video, CPU and memory signals of the ROM arbiter
interface rom_port_arbiter_if #(parameter int AW = 17);
    logic          DL_ACT;
    logic [24:0]   DL_ADDR;
    logic [7:0]    DL_DATA;
    logic          DL_WR;
    logic          VID_REQ;
    logic [AW-1:0] VID_ADDR;
    logic          VID_ACK;
    logic [7:0]    VID_DATA;
    logic          CPU_REQ;
    logic [AW-1:0] CPU_ADDR;
    logic          CPU_ACK;
    logic [7:0]    CPU_DATA;
    logic [AW-1:0] MEM_ADDR;
    logic [7:0]    MEM_WDATA;
    logic          MEM_WE;
    logic [7:0]    MEM_RDATA;
    logic          DL_DONE;
    logic          DL_ERR;
    modport slave (
        input  DL_ACT, DL_ADDR, DL_DATA, DL_WR, VID_REQ, VID_ADDR, CPU_REQ, CPU_ADDR, MEM_RDATA,
        output VID_ACK, VID_DATA, CPU_ACK, CPU_DATA, MEM_ADDR, MEM_WDATA, MEM_WE, DL_DONE, DL_ERR
    );
    modport master (
        output DL_ACT, DL_ADDR, DL_DATA, DL_WR, VID_REQ, VID_ADDR, CPU_REQ, CPU_ADDR, MEM_RDATA,
        input  VID_ACK, VID_DATA, CPU_ACK, CPU_DATA, MEM_ADDR, MEM_WDATA, MEM_WE, DL_DONE, DL_ERR
    );
endinterface

// File: rtl/rom_dl_hold.sv
// rom_dl_hold: one-entry download write buffer with limit filter and overrun flag
module rom_dl_hold
    import rom_arb_pkg::*;
#(
    parameter int          AW       = 17,
    parameter logic [24:0] DL_LIMIT = DL_LIMIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [24:0]   wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          drain,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          err
);
    logic in_range;
    assign in_range = wr_addr < DL_LIMIT;
    // load in-range bytes when the slot is free or draining; a byte arriving on a busy slot is lost and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            err   <= 1'b0;
        end else if (wr && in_range && (!valid || drain)) begin
            valid <= 1'b1;
            addr  <= wr_addr[AW-1:0];
            data  <= wr_data;
        end else begin
            valid <= valid && !drain;
            err   <= err || (wr && in_range);
        end
    end
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one registered-read memory between download writes, video and CPU fetches
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          AW       = 17,
    parameter logic [24:0] DL_LIMIT = DL_LIMIT_DEFAULT
) (
    input logic              MCLK,
    input logic              RESET_N,
    rom_port_arbiter_if.slave bus
);
    state_e        state, next_state;
    sel_e          sel;
    logic [1:0]    vid_cnt;
    logic          dl_act_q, pend;
    logic          hold_valid, hold_err;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_data;
    logic          drain, grant, pick_cpu, waiting, fire;
    rom_dl_hold #(.AW(AW), .DL_LIMIT(DL_LIMIT)) u_hold (
        .clk    (MCLK),
        .rst_n  (RESET_N),
        .wr     (bus.DL_WR),
        .wr_addr(bus.DL_ADDR),
        .wr_data(bus.DL_DATA),
        .drain  (drain),
        .valid  (hold_valid),
        .addr   (hold_addr),
        .data   (hold_data),
        .err    (hold_err)
    );
    assign bus.DL_ERR = hold_err;
    // arbitration: pending download write first, reads only outside download, CPU forced after two video grants
    always_comb begin
        drain      = state == IDLE && hold_valid;
        grant      = state == IDLE && !hold_valid && !bus.DL_ACT && (bus.VID_REQ || bus.CPU_REQ);
        pick_cpu   = bus.CPU_REQ && (!bus.VID_REQ || vid_cnt == 2'd2);
        waiting    = (pend || (dl_act_q && !bus.DL_ACT)) && !bus.DL_ACT;
        fire       = waiting && !hold_valid && state == IDLE;
        next_state = state == ISSUE ? CAPTURE : state == CAPTURE ? ACK : grant ? ISSUE : IDLE;
    end
    // read sequencing, memory port registers and per-port data/ack capture
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            sel           <= SEL_VID;
            vid_cnt       <= 2'd0;
            bus.MEM_WE    <= 1'b0;
            bus.MEM_ADDR  <= '0;
            bus.MEM_WDATA <= '0;
            bus.VID_ACK   <= 1'b0;
            bus.CPU_ACK   <= 1'b0;
            bus.VID_DATA  <= '0;
            bus.CPU_DATA  <= '0;
        end else begin
            state       <= next_state;
            bus.MEM_WE  <= drain;
            bus.VID_ACK <= state == CAPTURE && sel == SEL_VID;
            bus.CPU_ACK <= state == CAPTURE && sel == SEL_CPU;
            if (drain) begin
                bus.MEM_ADDR  <= hold_addr;
                bus.MEM_WDATA <= hold_data;
            end else if (grant) begin
                bus.MEM_ADDR <= pick_cpu ? bus.CPU_ADDR : bus.VID_ADDR;
                sel          <= pick_cpu ? SEL_CPU : SEL_VID;
                vid_cnt      <= pick_cpu ? 2'd0 : vid_cnt == 2'd2 ? 2'd2 : vid_cnt + 2'd1;
            end
            if (state == CAPTURE && sel == SEL_VID) bus.VID_DATA <= bus.MEM_RDATA;
            if (state == CAPTURE && sel == SEL_CPU) bus.CPU_DATA <= bus.MEM_RDATA;
        end
    end
    // completion pulse once download has ended and the last byte is in memory
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dl_act_q    <= 1'b0;
            pend        <= 1'b0;
            bus.DL_DONE <= 1'b0;
        end else begin
            dl_act_q    <= bus.DL_ACT;
            pend        <= waiting && !fire;
            bus.DL_DONE <= fire;
        end
    end
endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 17, memory address width (bytes).
REQ-002 SHALL have parameter DL_LIMIT, default 'h20000, first download address not written to memory.
REQ-003 SHALL have port MCLK  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DL_ACT  input  1  download in progress.
REQ-006 SHALL have ports DL_ADDR  input  25, DL_DATA  input  8, DL_WR  input  1  single-cycle download write strobe.
REQ-007 SHALL have ports VID_REQ  input  1, VID_ADDR  input  AW, VID_ACK  output  1, VID_DATA  output  8  video fetch port.
REQ-008 SHALL have ports CPU_REQ  input  1, CPU_ADDR  input  AW, CPU_ACK  output  1, CPU_DATA  output  8  CPU fetch port.
REQ-009 SHALL have ports MEM_ADDR  output  AW, MEM_WDATA  output  8, MEM_WE  output  1, MEM_RDATA  input  8  single-port memory, one-cycle registered read.
REQ-010 SHALL have ports DL_DONE  output  1  completion pulse, DL_ERR  output  1  sticky overrun flag.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, CAPTURE, ACK; one memory access outstanding at a time.
REQ-012 SHALL capture DL_WR into a one-entry hold register (address, data, valid) when DL_ADDR < DL_LIMIT; DL_WR with DL_ADDR >= DL_LIMIT SHALL be discarded without error.
REQ-013 SHALL, when DL_WR arrives while the hold register is valid and not draining that cycle, drop the new byte and set DL_ERR until reset.
REQ-014 SHALL in IDLE select with priority: valid hold register > VID_REQ > CPU_REQ.
REQ-015 SHALL drain a hold write in one cycle: MEM_WE=1, MEM_ADDR/MEM_WDATA from hold, valid cleared, FSM remains IDLE.
REQ-016 SHALL not grant VID_REQ or CPU_REQ while DL_ACT=1; requests remain pending.
REQ-017 SHALL, on read grant in IDLE (cycle N), register MEM_ADDR=requester address, enter ISSUE at N+1, CAPTURE at N+2 latching MEM_RDATA into that requester's DATA register, ACK at N+3 with that requester's ACK high for exactly one cycle.
REQ-018 SHALL hold VID_DATA/CPU_DATA stable between that port's ACKs.
REQ-019 SHALL require requesters to hold REQ and ADDR stable until ACK; the ACK state SHALL return to IDLE and a REQ still high there SHALL be treated as a new request.
REQ-020 SHALL, after two consecutive VID grants with CPU_REQ pending, grant CPU next regardless of VID_REQ (anti-starvation counter, cleared on any CPU grant).
REQ-021 SHALL keep MEM_WE=0 in every cycle except a drain cycle.
REQ-022 SHALL pulse DL_DONE for one cycle at the first cycle after DL_ACT falls with hold register empty and FSM in IDLE.
REQ-023 SHALL, when DL_ACT rises during ISSUE/CAPTURE/ACK, complete that read normally before honouring REQ-016.
REQ-024 SHALL accept a DL_WR in the same cycle the hold register drains without setting DL_ERR.

Reset
REQ-025 SHALL on RESET_N=0 asynchronously force: FSM=IDLE, hold valid=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, VID_ACK=CPU_ACK=0, VID_DATA=CPU_DATA=0, DL_DONE=0, DL_ERR=0, starvation counter=0.
REQ-026 SHALL on reset mid-read abandon the access with no ACK issued.

Structure
REQ-027 SHALL place FSM state enum, requester-select enum and DL_LIMIT default in shared package rom_arb_pkg.
REQ-028 SHALL be one module with a natural sub-module rom_dl_hold (hold register, limit check, overrun detect).

Verification
REQ-029 Single VID read: VID_REQ=1, VID_ADDR='h00100, memory holds 'hA5 -> VID_ACK high exactly at cycle N+3, VID_DATA='hA5.
REQ-030 Simultaneous VID_REQ and CPU_REQ held continuously -> grant order VID, VID, CPU, VID, VID, CPU.
REQ-031 Download: DL_ACT=1, DL_WR at 'h00000='h11 and 'h1FFFF='h22 -> MEM_WE pulses with those address/data; write at 'h20000 produces no MEM_WE, DL_ERR=0.
REQ-032 Two DL_WR strobes on consecutive cycles during an in-flight read (DL_ACT rising mid-read) -> second byte dropped, DL_ERR=1, read still ACKed.
REQ-033 DL_ACT falls with hold pending -> drain write, then DL_DONE one-cycle pulse; pending CPU_REQ granted afterwards.
REQ-034 RESET_N low at CAPTURE -> all outputs zero immediately, no ACK after release, next request served normally.
